placar_param: RTL and testbench

- Parametrised successor of the single-game scoreboard: tracks score and lives, runs the game-state FSM and drives N-digit 7-segment displays.
- Adds internal edge detection on all event inputs, configurable points per block, bonus lives, a win state, restart without reset, and leading-zero blanking on any digit count.
- Sits between the game logic (ball/block/lava collision flags) and the board's HEX displays.

---
 rtl/placar_pkg.sv | 37 +++
 rtl/bcd_param.sv | 36 +++
 rtl/cb7s.sv | 13 +
 rtl/placar_param.sv | 202 ++++++++++++++++++++
 tb/tb_placar_param.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/placar_pkg.sv
// placar_pkg: shared definitions for the placar_param scoreboard.
//   state_t     game FSM state encodings (IDLE=0 .. WIN=4)
//   SEG_BLANK   active-low pattern for a dark digit
//   SEG_TABLE   hex digit -> active-low 7-segment pattern, bit order gfedcba
//   bcd_bits()  number of BCD bits needed to hold any value of a given width
package placar_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PLAY = 3'd1,
        ST_LOSE = 3'd2,
        ST_OVER = 3'd3,
        ST_WIN  = 3'd4
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic int unsigned bcd_bits(input int unsigned width);
        longint unsigned v;
        int unsigned     d;
        v = (64'd1 << width) - 64'd1;
        d = 1;
        for (int unsigned i = 0; i < 20; i++) begin
            if (v >= 64'd10) begin
                v = v / 64'd10;
                d = d + 1;
            end
        end
        return 4 * d;
    endfunction

endpackage

// File: rtl/bcd_param.sv
// bcd_param: combinational binary-to-BCD converter (double dabble).
//   bin  in   BIN_W-bit unsigned value
//   bcd  out  DIGITS packed BCD digits, digit 0 in bits [3:0]
module bcd_param
    import placar_pkg::*;
#(
    parameter int unsigned BIN_W  = 14,
    parameter int unsigned DIGITS = 4
) (
    input  logic [BIN_W-1:0]    bin,
    output logic [4*DIGITS-1:0] bcd
);

    // Lower digits never depend on higher ones, so the accumulator only needs
    // the digits that are both displayed and reachable by BIN_W bits.
    localparam int unsigned NEED  = bcd_bits(BIN_W);
    localparam int unsigned ACC_W = (NEED < 4 * DIGITS) ? NEED : 4 * DIGITS;
    localparam int unsigned ACC_D = ACC_W / 4;

    logic [ACC_W-1:0] acc;

    always_comb begin
        acc = '0;
        for (int unsigned i = 0; i < BIN_W; i++) begin
            for (int unsigned d = 0; d < ACC_D; d++) begin
                if (acc[4*d +: 4] >= 4'd5) begin
                    acc[4*d +: 4] = acc[4*d +: 4] + 4'd3;
                end
            end
            acc = {acc[ACC_W-2:0], bin[BIN_W-1-i]};
        end
    end

    assign bcd = (4*DIGITS)'(acc);

endmodule

// File: rtl/cb7s.sv
// cb7s: hex digit to active-low 7-segment decoder.
//   hex  in   4-bit digit value
//   seg  out  active-low segments gfedcba
module cb7s
    import placar_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[hex];

endmodule

// File: rtl/placar_param.sv
// placar_param: parametrised game scoreboard (score, lives, game FSM, displays).
//   clock, reset (async, active-low)
//   start, hit_block, hit_lava, endgame_block, all_blocks_cleared: level inputs,
//     each acted on once per rising edge
//   vidas_restantes / pontuacao_atual: lives and score registers
//   estado_jogo: FSM state, game_over / win: OVER / WIN flags
//   score_seg / lives_seg: active-low digits, digit 0 in bits [6:0],
//     leading zeros blanked
// Optional feature: define PLACAR_HISCORE_EN to add a high-score register,
// the hiscore output, and hiscore display while in OVER or WIN.
module placar_param
    import placar_pkg::*;
#(
    parameter int unsigned SCORE_W       = 14,
    parameter int unsigned SCORE_DIGITS  = 4,
    parameter int unsigned LIVES_W       = 4,
    parameter int unsigned LIVES_DIGITS  = 2,
    parameter int unsigned INIT_LIVES    = 3,
    parameter int unsigned MAX_LIVES     = 9,
    parameter int unsigned PTS_PER_BLOCK = 1,
    parameter int unsigned BONUS_EVERY   = 0
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      hit_block,
    input  logic                      hit_lava,
    input  logic                      endgame_block,
    input  logic                      all_blocks_cleared,
    output logic [LIVES_W-1:0]        vidas_restantes,
    output logic [SCORE_W-1:0]        pontuacao_atual,
    output logic [2:0]                estado_jogo,
    output logic                      game_over,
    output logic                      win,
    output logic [7*SCORE_DIGITS-1:0] score_seg,
    output logic [7*LIVES_DIGITS-1:0] lives_seg
`ifdef PLACAR_HISCORE_EN
    ,
    output logic [SCORE_W-1:0]        hiscore
`endif
);

    localparam int unsigned      SMAX   = 10**SCORE_DIGITS - 1;
    localparam logic [SCORE_W:0] SMAX_X = (SCORE_W+1)'(SMAX);
    localparam logic [SCORE_W:0] PTS_X  = (SCORE_W+1)'(PTS_PER_BLOCK);
    localparam logic [SCORE_W:0] BDIV_X = (SCORE_W+1)'((BONUS_EVERY == 0) ? 1 : BONUS_EVERY);
    localparam logic [LIVES_W-1:0] INIT_L = LIVES_W'(INIT_LIVES);
    localparam logic [LIVES_W-1:0] MAX_L  = LIVES_W'(MAX_LIVES);
    localparam logic [LIVES_W-1:0] ONE_L  = LIVES_W'(1);

    state_t               state_q, state_d;
    logic [SCORE_W-1:0]   score_q, score_d, score_hit;
    logic [LIVES_W-1:0]   lives_q, lives_d, lives_bonus;
    logic [4:0]           ev_q, ev_in, ev_pulse;
    logic [SCORE_W:0]     sum_x;
    logic                 bonus;

    // Event bits: 0 start, 1 hit_block, 2 hit_lava, 3 endgame_block, 4 all_blocks_cleared
    assign ev_in    = {all_blocks_cleared, endgame_block, hit_lava, hit_block, start};
    assign ev_pulse = ev_in & ~ev_q;

    assign sum_x     = {1'b0, score_q} + PTS_X;
    assign score_hit = (sum_x > SMAX_X) ? SMAX_X[SCORE_W-1:0] : sum_x[SCORE_W-1:0];
    assign bonus     = (BONUS_EVERY != 0) &&
                       (({1'b0, score_q} / BDIV_X) != ({1'b0, score_hit} / BDIV_X));
    assign lives_bonus = (bonus && (lives_q < MAX_L)) ? lives_q + ONE_L : lives_q;

    always_comb begin
        state_d = state_q;
        score_d = score_q;
        lives_d = lives_q;
        case (state_q)
            ST_IDLE: begin
                if (ev_pulse[0]) state_d = ST_PLAY;
            end
            ST_PLAY: begin
                if (ev_pulse[1]) begin
                    score_d = score_hit;
                    lives_d = lives_bonus;
                end
                if (ev_pulse[3])      state_d = ST_OVER;
                else if (ev_pulse[4]) state_d = ST_WIN;
                else if (ev_pulse[2]) state_d = ST_LOSE;
            end
            ST_LOSE: begin
                if (lives_q != '0) lives_d = lives_q - ONE_L;
                state_d = (lives_q <= ONE_L) ? ST_OVER : ST_IDLE;
            end
            ST_OVER, ST_WIN: begin
                if (ev_pulse[0]) begin
                    score_d = '0;
                    lives_d = INIT_L;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            score_q <= '0;
            lives_q <= INIT_L;
            ev_q    <= '0;
        end else begin
            state_q <= state_d;
            score_q <= score_d;
            lives_q <= lives_d;
            ev_q    <= ev_in;
        end
    end

    lives_no_underflow: assert property (@(posedge clock) disable iff (!reset)
        (state_q == ST_LOSE) |-> (lives_q != '0));

    assign vidas_restantes = lives_q;
    assign pontuacao_atual = score_q;
    assign estado_jogo     = state_q;
    assign game_over       = (state_q == ST_OVER);
    assign win             = (state_q == ST_WIN);

    logic [4*SCORE_DIGITS-1:0] score_bcd, disp_bcd;
    logic [4*LIVES_DIGITS-1:0] lives_bcd;
    logic [7*SCORE_DIGITS-1:0] score_raw;
    logic [7*LIVES_DIGITS-1:0] lives_raw;

    bcd_param #(.BIN_W(SCORE_W), .DIGITS(SCORE_DIGITS)) u_bcd_score (
        .bin (score_q),
        .bcd (score_bcd)
    );

    bcd_param #(.BIN_W(LIVES_W), .DIGITS(LIVES_DIGITS)) u_bcd_lives (
        .bin (lives_q),
        .bcd (lives_bcd)
    );

`ifdef PLACAR_HISCORE_EN
    logic [SCORE_W-1:0]        hiscore_q;
    logic [4*SCORE_DIGITS-1:0] hiscore_bcd;
    logic                      end_d, end_q;

    assign end_d = (state_d == ST_OVER) || (state_d == ST_WIN);
    assign end_q = (state_q == ST_OVER) || (state_q == ST_WIN);

    // score_d is the score the game ends with, including a same-cycle hit
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hiscore_q <= '0;
        end else if (end_d && !end_q && (score_d > hiscore_q)) begin
            hiscore_q <= score_d;
        end
    end

    bcd_param #(.BIN_W(SCORE_W), .DIGITS(SCORE_DIGITS)) u_bcd_hiscore (
        .bin (hiscore_q),
        .bcd (hiscore_bcd)
    );

    assign hiscore  = hiscore_q;
    assign disp_bcd = end_q ? hiscore_bcd : score_bcd;
`else
    assign disp_bcd = score_bcd;
`endif

    for (genvar g = 0; g < SCORE_DIGITS; g++) begin : g_score_dec
        cb7s u_dec (.hex(disp_bcd[4*g +: 4]), .seg(score_raw[7*g +: 7]));
    end

    for (genvar g = 0; g < LIVES_DIGITS; g++) begin : g_lives_dec
        cb7s u_dec (.hex(lives_bcd[4*g +: 4]), .seg(lives_raw[7*g +: 7]));
    end

    // Walk from the most significant digit down; a digit lights once any
    // digit at or above it is non-zero. Digit 0 is always lit.
    always_comb begin
        logic seen;
        seen      = 1'b0;
        score_seg = '1;
        for (int unsigned k = 0; k < SCORE_DIGITS; k++) begin
            if (disp_bcd[4*(SCORE_DIGITS-1-k) +: 4] != 4'd0) seen = 1'b1;
            if (seen || (k == SCORE_DIGITS - 1))
                score_seg[7*(SCORE_DIGITS-1-k) +: 7] = score_raw[7*(SCORE_DIGITS-1-k) +: 7];
            else
                score_seg[7*(SCORE_DIGITS-1-k) +: 7] = SEG_BLANK;
        end
    end

    always_comb begin
        logic seen;
        seen      = 1'b0;
        lives_seg = '1;
        for (int unsigned k = 0; k < LIVES_DIGITS; k++) begin
            if (lives_bcd[4*(LIVES_DIGITS-1-k) +: 4] != 4'd0) seen = 1'b1;
            if (seen || (k == LIVES_DIGITS - 1))
                lives_seg[7*(LIVES_DIGITS-1-k) +: 7] = lives_raw[7*(LIVES_DIGITS-1-k) +: 7];
            else
                lives_seg[7*(LIVES_DIGITS-1-k) +: 7] = SEG_BLANK;
        end
    end

endmodule

// File: tb/tb_placar_param.sv
// tb_placar_param: self-checking bench for placar_param.
//   u0: default parameters, u1: BONUS_EVERY=5 / PTS_PER_BLOCK=2,
//   u2: SCORE_DIGITS=2 / SCORE_W=7. Expected score/lives/state are queued
//   as stimulus is driven and compared by a monitor one cycle later.
module tb_placar_param;

    localparam int IDLE = 0, PLAY = 1, LOSE = 2, OVER = 3, WIN = 4;
    localparam int EV_ST = 1, EV_HB = 2, EV_HL = 4, EV_EG = 8, EV_AC = 16;

    localparam logic [6:0] SB = 7'h7F, SD0 = 7'h40, SD1 = 7'h79, SD3 = 7'h30;
    localparam logic [6:0] SD6 = 7'h02, SD7 = 7'h78, SD9 = 7'h10;

    logic       clock;
    logic [2:0] rst_v, start_v, hb_v, hl_v, eg_v, ac_v;

    logic [13:0] sc0, sc1;
    logic [6:0]  sc2;
    logic [3:0]  lv0, lv1, lv2;
    logic [2:0]  st0, st1, st2;
    logic        go0, go1, go2, wn0, wn1, wn2;
    logic [27:0] ss0, ss1;
    logic [13:0] ss2;
    logic [13:0] ls0, ls1, ls2;
`ifdef PLACAR_HISCORE_EN
    logic [13:0] hs0, hs1;
    logic [6:0]  hs2;
`endif

    placar_param u0 (
        .clock(clock), .reset(rst_v[0]), .start(start_v[0]), .hit_block(hb_v[0]),
        .hit_lava(hl_v[0]), .endgame_block(eg_v[0]), .all_blocks_cleared(ac_v[0]),
        .vidas_restantes(lv0), .pontuacao_atual(sc0), .estado_jogo(st0),
        .game_over(go0), .win(wn0), .score_seg(ss0), .lives_seg(ls0)
`ifdef PLACAR_HISCORE_EN
        , .hiscore(hs0)
`endif
    );

    placar_param #(.BONUS_EVERY(5), .PTS_PER_BLOCK(2)) u1 (
        .clock(clock), .reset(rst_v[1]), .start(start_v[1]), .hit_block(hb_v[1]),
        .hit_lava(hl_v[1]), .endgame_block(eg_v[1]), .all_blocks_cleared(ac_v[1]),
        .vidas_restantes(lv1), .pontuacao_atual(sc1), .estado_jogo(st1),
        .game_over(go1), .win(wn1), .score_seg(ss1), .lives_seg(ls1)
`ifdef PLACAR_HISCORE_EN
        , .hiscore(hs1)
`endif
    );

    placar_param #(.SCORE_W(7), .SCORE_DIGITS(2)) u2 (
        .clock(clock), .reset(rst_v[2]), .start(start_v[2]), .hit_block(hb_v[2]),
        .hit_lava(hl_v[2]), .endgame_block(eg_v[2]), .all_blocks_cleared(ac_v[2]),
        .vidas_restantes(lv2), .pontuacao_atual(sc2), .estado_jogo(st2),
        .game_over(go2), .win(wn2), .score_seg(ss2), .lives_seg(ls2)
`ifdef PLACAR_HISCORE_EN
        , .hiscore(hs2)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int          idx;
        int          due;
        logic [31:0] score;
        logic [31:0] lives;
        logic [31:0] state;
        string       tag;
    } exp_t;

    exp_t sb[$];

    function automatic logic [31:0] obs_score(input int idx);
        case (idx)
            0:       return 32'(sc0);
            1:       return 32'(sc1);
            default: return 32'(sc2);
        endcase
    endfunction

    function automatic logic [31:0] obs_lives(input int idx);
        case (idx)
            0:       return 32'(lv0);
            1:       return 32'(lv1);
            default: return 32'(lv2);
        endcase
    endfunction

    function automatic logic [31:0] obs_state(input int idx);
        case (idx)
            0:       return 32'(st0);
            1:       return 32'(st1);
            default: return 32'(st2);
        endcase
    endfunction

    // Monitor: compares every queued expectation on the cycle it falls due.
    always begin
        exp_t e;
        @(posedge clock);
        #1;
        cyc++;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            checks++;
            if (obs_score(e.idx) !== e.score) begin
                failures++;
                $display("FAIL %s score u%0d got=%0d exp=%0d", e.tag, e.idx, obs_score(e.idx), e.score);
            end
            checks++;
            if (obs_lives(e.idx) !== e.lives) begin
                failures++;
                $display("FAIL %s lives u%0d got=%0d exp=%0d", e.tag, e.idx, obs_lives(e.idx), e.lives);
            end
            checks++;
            if (obs_state(e.idx) !== e.state) begin
                failures++;
                $display("FAIL %s state u%0d got=%0d exp=%0d", e.tag, e.idx, obs_state(e.idx), e.state);
            end
        end
    end

    task automatic push(input int idx, input string tag, input int s, input int l, input int st);
        exp_t e;
        e.idx   = idx;
        e.due   = cyc + 1;
        e.score = s;
        e.lives = l;
        e.state = st;
        e.tag   = tag;
        sb.push_back(e);
    endtask

    // One-cycle event pulse on instance idx; expectation is checked after the edge.
    task automatic fire(input int idx, input int mask, input string tag,
                        input int s, input int l, input int st);
        @(negedge clock);
        start_v[idx] = mask[0];
        hb_v[idx]    = mask[1];
        hl_v[idx]    = mask[2];
        eg_v[idx]    = mask[3];
        ac_v[idx]    = mask[4];
        push(idx, tag, s, l, st);
        @(negedge clock);
        start_v[idx] = 1'b0;
        hb_v[idx]    = 1'b0;
        hl_v[idx]    = 1'b0;
        eg_v[idx]    = 1'b0;
        ac_v[idx]    = 1'b0;
    endtask

    // Expectation for the cycle after a LOSE.
    task automatic settle(input int idx, input string tag, input int s, input int l, input int st);
        push(idx, tag, s, l, st);
        @(negedge clock);
    endtask

    task automatic test_reset;
        rst_v = 3'b000; start_v = '0; hb_v = '0; hl_v = '0; eg_v = '0; ac_v = '0;
        repeat (2) @(negedge clock);
        checks++; if (sc0 !== 14'd0 || sc1 !== 14'd0 || sc2 !== 7'd0) begin
            failures++; $display("FAIL reset_score got=%0d/%0d/%0d exp=0", sc0, sc1, sc2); end
        checks++; if (lv0 !== 4'd3 || lv1 !== 4'd3 || lv2 !== 4'd3) begin
            failures++; $display("FAIL reset_lives got=%0d/%0d/%0d exp=3", lv0, lv1, lv2); end
        checks++; if (st0 !== 3'd0 || st1 !== 3'd0 || st2 !== 3'd0) begin
            failures++; $display("FAIL reset_state got=%0d/%0d/%0d exp=0", st0, st1, st2); end
        checks++; if ({go0, go1, go2, wn0, wn1, wn2} !== 6'b0) begin
            failures++; $display("FAIL reset_flags got=%b exp=000000", {go0, go1, go2, wn0, wn1, wn2}); end
        checks++; if (ss0 !== {SB, SB, SB, SD0}) begin
            failures++; $display("FAIL reset_score_seg got=%h exp=%h", ss0, {SB, SB, SB, SD0}); end
        checks++; if (ls0 !== {SB, SD3}) begin
            failures++; $display("FAIL reset_lives_seg got=%h exp=%h", ls0, {SB, SD3}); end
`ifdef PLACAR_HISCORE_EN
        checks++; if (hs0 !== 14'd0) begin
            failures++; $display("FAIL reset_hiscore got=%0d exp=0", hs0); end
`endif
        rst_v = 3'b111;
    endtask

    task automatic test_start;
        fire(0, EV_HB, "idle_ignore", 0, 3, IDLE);
        fire(0, EV_ST, "start", 0, 3, PLAY);
        checks++; if (ss0 !== {SB, SB, SB, SD0} || ls0 !== {SB, SD3}) begin
            failures++; $display("FAIL start_segs got=%h/%h exp=%h/%h", ss0, ls0, {SB, SB, SB, SD0}, {SB, SD3}); end
    endtask

    task automatic test_hold_hit;
        @(negedge clock);
        hb_v[0] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            push(0, "hold", 1, 3, PLAY);
            @(negedge clock);
        end
        hb_v[0] = 1'b0;
        for (int i = 0; i < 5; i++) fire(0, EV_HB, "pulses", 2 + i, 3, PLAY);
        checks++; if (ss0 !== {SB, SB, SB, SD6}) begin
            failures++; $display("FAIL seg_six got=%h exp=%h", ss0, {SB, SB, SB, SD6}); end
    endtask

    task automatic test_lava;
        fire(0, EV_HB | EV_HL, "hit_and_lava", 7, 3, LOSE);
        settle(0, "hit_and_lava_after", 7, 2, IDLE);
        fire(0, EV_ST, "serve2", 7, 2, PLAY);
        fire(0, EV_HL, "lava2", 7, 2, LOSE);
        settle(0, "lava2_after", 7, 1, IDLE);
        fire(0, EV_ST, "serve3", 7, 1, PLAY);
        fire(0, EV_HL, "lava3", 7, 1, LOSE);
        settle(0, "lava3_after", 7, 0, OVER);
        checks++; if (go0 !== 1'b1 || wn0 !== 1'b0) begin
            failures++; $display("FAIL over_flags got=%b%b exp=10", go0, wn0); end
        checks++; if (ls0 !== {SB, SD0}) begin
            failures++; $display("FAIL lives_zero_seg got=%h exp=%h", ls0, {SB, SD0}); end
        fire(0, EV_HL, "lava_in_over", 7, 0, OVER);
        fire(0, EV_HB, "hit_in_over", 7, 0, OVER);
`ifdef PLACAR_HISCORE_EN
        checks++; if (hs0 !== 14'd7) begin
            failures++; $display("FAIL hiscore_over got=%0d exp=7", hs0); end
`endif
        fire(0, EV_ST, "restart", 0, 3, IDLE);
        checks++; if (go0 !== 1'b0 || ss0 !== {SB, SB, SB, SD0}) begin
            failures++; $display("FAIL restart_out got=%b/%h exp=0/%h", go0, ss0, {SB, SB, SB, SD0}); end
    endtask

    task automatic test_priority;
        fire(0, EV_ST, "prio_serve", 0, 3, PLAY);
        fire(0, EV_EG | EV_AC, "endgame_over_win", 0, 3, OVER);
        checks++; if (go0 !== 1'b1 || wn0 !== 1'b0) begin
            failures++; $display("FAIL prio_flags got=%b%b exp=10", go0, wn0); end
        fire(0, EV_ST, "prio_restart", 0, 3, IDLE);
        fire(0, EV_ST, "prio_serve2", 0, 3, PLAY);
        fire(0, EV_AC | EV_HL | EV_HB, "win_over_lava", 1, 3, WIN);
        checks++; if (wn0 !== 1'b1 || go0 !== 1'b0) begin
            failures++; $display("FAIL win_flags got=%b%b exp=10", wn0, go0); end
`ifdef PLACAR_HISCORE_EN
        checks++; if (hs0 !== 14'd7 || ss0 !== {SB, SB, SB, SD7}) begin
            failures++; $display("FAIL win_hiscore got=%0d/%h exp=7/%h", hs0, ss0, {SB, SB, SB, SD7}); end
`else
        checks++; if (ss0 !== {SB, SB, SB, SD1}) begin
            failures++; $display("FAIL win_seg got=%h exp=%h", ss0, {SB, SB, SB, SD1}); end
`endif
        fire(0, EV_ST, "win_restart", 0, 3, IDLE);
    endtask

    task automatic test_reset_mid_lose;
        fire(0, EV_ST, "mid_serve", 0, 3, PLAY);
        fire(0, EV_HB, "mid_hit", 1, 3, PLAY);
        fire(0, EV_HL, "mid_lava", 1, 3, LOSE);
        rst_v[0] = 1'b0;
        #1;
        checks++; if (st0 !== 3'd0 || lv0 !== 4'd3 || sc0 !== 14'd0) begin
            failures++; $display("FAIL async_reset got=st%0d/l%0d/s%0d exp=st0/l3/s0", st0, lv0, sc0); end
        @(negedge clock);
        rst_v[0] = 1'b1;
    endtask

    task automatic test_bonus;
        int el;
        fire(1, EV_ST, "bonus_serve", 0, 3, PLAY);
        for (int k = 1; k <= 18; k++) begin
            el = 3 + (2 * k) / 5;
            if (el > 9) el = 9;
            fire(1, EV_HB, "bonus", 2 * k, el, PLAY);
        end
        checks++; if (ss1 !== {SB, SB, SD3, SD6} || ls1 !== {SB, SD9}) begin
            failures++; $display("FAIL bonus_segs got=%h/%h exp=%h/%h", ss1, ls1, {SB, SB, SD3, SD6}, {SB, SD9}); end
        fire(1, EV_HB, "b38", 38, 9, PLAY);
        fire(1, EV_HL, "b_lava1", 38, 9, LOSE);
        settle(1, "b_lava1_after", 38, 8, IDLE);
        fire(1, EV_ST, "b_serve1", 38, 8, PLAY);
        fire(1, EV_HB, "b40", 40, 9, PLAY);
        fire(1, EV_HL, "b_lava2", 40, 9, LOSE);
        settle(1, "b_lava2_after", 40, 8, IDLE);
        fire(1, EV_ST, "b_serve2", 40, 8, PLAY);
        fire(1, EV_HB, "b42", 42, 8, PLAY);
        fire(1, EV_HB, "b44", 44, 8, PLAY);
        fire(1, EV_HB | EV_HL, "bonus_and_lava", 46, 9, LOSE);
        settle(1, "bonus_and_lava_after", 46, 8, IDLE);
    endtask

    task automatic test_saturation;
        fire(2, EV_ST, "sat_serve", 0, 3, PLAY);
        for (int k = 1; k <= 120; k++) fire(2, EV_HB, "sat", (k > 99) ? 99 : k, 3, PLAY);
        fire(2, EV_AC, "sat_win", 99, 3, WIN);
        checks++; if (wn2 !== 1'b1 || ss2 !== {SD9, SD9}) begin
            failures++; $display("FAIL sat_win_out got=%b/%h exp=1/%h", wn2, ss2, {SD9, SD9}); end
`ifdef PLACAR_HISCORE_EN
        checks++; if (hs2 !== 7'd99) begin
            failures++; $display("FAIL sat_hiscore got=%0d exp=99", hs2); end
`endif
        fire(2, EV_ST, "sat_restart", 0, 3, IDLE);
        checks++; if (ss2 !== {SB, SD0}) begin
            failures++; $display("FAIL sat_restart_seg got=%h exp=%h", ss2, {SB, SD0}); end
`ifdef PLACAR_HISCORE_EN
        checks++; if (hs2 !== 7'd99) begin
            failures++; $display("FAIL sat_hiscore_kept got=%0d exp=99", hs2); end
`endif
    endtask

    initial begin
        test_reset();
        test_start();
        test_hold_hit();
        test_lava();
        test_priority();
        test_reset_mid_lose();
        test_bonus();
        test_saturation();
        repeat (4) @(negedge clock);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d pending exp=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
